// File: rtl/elevator_collision_tracker_pkg.sv
// Shared types and constants for the elevator collision tracker.
// Lane bus slicing helper keeps packed-lane indexing in one place.
package elevator_pkg;

    typedef enum logic [1:0] {
        PLAY = 2'd0,
        HOLD = 2'd1,
        OVER = 2'd2
    } state_t;

    localparam int DEF_NUM_ELEV = 3;
    localparam int DEF_COORD_W  = 10;
    localparam int DEF_SCORE_W  = 8;
    localparam int DEF_LIVES    = 3;
    localparam int DEF_HOLDOFF  = 30;

    function automatic int lane_lo(input int i, input int w);
        return i * w;
    endfunction

endpackage

// File: rtl/elevator_collision_tracker_if.sv
// Bundle between position logic, the tracker and the display blocks.
// master drives frame/lane/player inputs, slave is the tracker.
interface elevator_collision_tracker_if #(
    parameter int NUM_ELEV = 3,
    parameter int COORD_W  = 10,
    parameter int SCORE_W  = 8
);
    localparam int IDX_W = $clog2(NUM_ELEV) + 1;

    logic                        frame_tick;
    logic                        restart;
    logic [NUM_ELEV*COORD_W-1:0] elev_top;
    logic [NUM_ELEV*COORD_W-1:0] elev_bot;
    logic [NUM_ELEV*COORD_W-1:0] elev_l;
    logic [NUM_ELEV*COORD_W-1:0] elev_r;
    logic [COORD_W-1:0]          pt;
    logic [COORD_W-1:0]          pb;
    logic [COORD_W-1:0]          pl;
    logic [COORD_W-1:0]          pr;
    logic                        hit;
    logic [IDX_W-1:0]            hit_idx;
    logic                        in_gap;
    logic                        inc_score;
    logic [SCORE_W-1:0]          score;
    logic [2:0]                  lives;
    logic                        game_over;

    modport master (
        output frame_tick, restart,
        output elev_top, elev_bot, elev_l, elev_r,
        output pt, pb, pl, pr,
        input  hit, hit_idx, in_gap, inc_score,
        input  score, lives, game_over
    );

    modport slave (
        input  frame_tick, restart,
        input  elev_top, elev_bot, elev_l, elev_r,
        input  pt, pb, pl, pr,
        output hit, hit_idx, in_gap, inc_score,
        output score, lives, game_over
    );

endinterface

// File: rtl/elevator_collision_tracker_lane.sv
// One elevator lane: collision/gap/pass compares plus the arm flop
// that lets a lane score only once per upward crossing.
module elev_lane #(
    parameter int COORD_W = 10
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               frame_tick,
    input  logic               restart,
    input  logic               freeze,
    input  logic [COORD_W-1:0] top,
    input  logic [COORD_W-1:0] bot,
    input  logic [COORD_W-1:0] l,
    input  logic [COORD_W-1:0] r,
    input  logic [COORD_W-1:0] pt,
    input  logic [COORD_W-1:0] pb,
    input  logic [COORD_W-1:0] pl,
    input  logic [COORD_W-1:0] pr,
    output logic               col,
    output logic               gap,
    output logic               pass
);
    logic arm;
    logic vov;
    logic algn;

    assign vov  = (pt >= bot) && (pt < top);
    assign algn = (pl >= l) && (pr <= r);
    assign gap  = algn && (pt >= bot) && (pb <= top);
    assign col  = vov && !gap;
    assign pass = arm && (pb >= top);

    // Re-arm only once the player is fully below the lane again.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            arm <= 1'b1;
        end else if (restart) begin
            arm <= 1'b1;
        end else if (frame_tick && !freeze) begin
            if (pass) begin
                arm <= 1'b0;
            end else if (pb < bot) begin
                arm <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/elevator_collision_tracker.sv
// Frame-strobed collision tracker: N lanes vs player box, score,
// lives and a hit-holdoff / game-over state machine.
module elevator_collision_tracker
    import elevator_pkg::*;
#(
    parameter int NUM_ELEV = DEF_NUM_ELEV,
    parameter int COORD_W  = DEF_COORD_W,
    parameter int SCORE_W  = DEF_SCORE_W,
    parameter int LIVES    = DEF_LIVES,
    parameter int HOLDOFF  = DEF_HOLDOFF
) (
    input logic clk,
    input logic rst_n,
    elevator_collision_tracker_if.slave bus
);
    localparam int IDX_W = $clog2(NUM_ELEV) + 1;
    localparam int PC_W  = $clog2(NUM_ELEV + 1);
    localparam int SUM_W = ((SCORE_W > PC_W) ? SCORE_W : PC_W) + 1;
    localparam int CNT_W = $clog2(HOLDOFF + 1);

    localparam logic [SUM_W-1:0] SCORE_MAX  = SUM_W'({SCORE_W{1'b1}});
    localparam logic [2:0]       LIVES_INIT = 3'(LIVES);
    localparam logic [CNT_W-1:0] HOLD_LOAD  = CNT_W'(HOLDOFF - 1);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [SCORE_W-1:0] score_q, score_d;
    logic [2:0]         lives_q, lives_d;
    logic               hit_q, hit_d;
    logic               inc_q, inc_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               gap_q, gap_d;

    logic [NUM_ELEV-1:0] col;
    logic [NUM_ELEV-1:0] gap;
    logic [NUM_ELEV-1:0] pass;
    logic                over;
    logic [PC_W-1:0]     pc;
    logic [IDX_W-1:0]    col_idx;
    logic [SUM_W-1:0]    sum;
    logic [SCORE_W-1:0]  score_sat;

    assign over = (state_q == OVER);

    for (genvar i = 0; i < NUM_ELEV; i++) begin : g_lane
        elev_lane #(
            .COORD_W(COORD_W)
        ) u_lane (
            .clk       (clk),
            .rst_n     (rst_n),
            .frame_tick(bus.frame_tick),
            .restart   (bus.restart),
            .freeze    (over),
            .top       (bus.elev_top[lane_lo(i, COORD_W) +: COORD_W]),
            .bot       (bus.elev_bot[lane_lo(i, COORD_W) +: COORD_W]),
            .l         (bus.elev_l[lane_lo(i, COORD_W) +: COORD_W]),
            .r         (bus.elev_r[lane_lo(i, COORD_W) +: COORD_W]),
            .pt        (bus.pt),
            .pb        (bus.pb),
            .pl        (bus.pl),
            .pr        (bus.pr),
            .col       (col[i]),
            .gap       (gap[i]),
            .pass      (pass[i])
        );
    end

    always_comb begin
        pc      = '0;
        col_idx = '0;
        for (int i = 0; i < NUM_ELEV; i++) begin
            pc = pc + PC_W'(pass[i]);
        end
        // Scan downward so the lowest colliding lane wins.
        for (int i = NUM_ELEV - 1; i >= 0; i--) begin
            if (col[i]) begin
                col_idx = IDX_W'(i);
            end
        end
        sum = SUM_W'(score_q) + SUM_W'(pc);
        if (sum > SCORE_MAX) begin
            score_sat = SCORE_MAX[SCORE_W-1:0];
        end else begin
            score_sat = sum[SCORE_W-1:0];
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        score_d = score_q;
        lives_d = lives_q;
        hit_d   = 1'b0;
        inc_d   = 1'b0;
        idx_d   = idx_q;
        gap_d   = gap_q;
        if (bus.restart) begin
            state_d = PLAY;
            cnt_d   = '0;
            score_d = '0;
            lives_d = LIVES_INIT;
        end else if (bus.frame_tick && !over) begin
            score_d = score_sat;
            inc_d   = (score_sat != score_q);
            gap_d   = |gap;
            unique case (state_q)
                PLAY: begin
                    if (|col) begin
                        lives_d = lives_q - 3'd1;
                        hit_d   = 1'b1;
                        idx_d   = col_idx;
                        if (lives_q == 3'd1) begin
                            state_d = OVER;
                        end else begin
                            state_d = HOLD;
                            cnt_d   = HOLD_LOAD;
                        end
                    end
                end
                HOLD: begin
                    if (cnt_q == '0) begin
                        state_d = PLAY;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                default: begin
                    state_d = state_q;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= PLAY;
            cnt_q   <= '0;
            score_q <= '0;
            lives_q <= LIVES_INIT;
            hit_q   <= 1'b0;
            inc_q   <= 1'b0;
            idx_q   <= '0;
            gap_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            score_q <= score_d;
            lives_q <= lives_d;
            hit_q   <= hit_d;
            inc_q   <= inc_d;
            idx_q   <= idx_d;
            gap_q   <= gap_d;
        end
    end

    assign bus.hit       = hit_q;
    assign bus.hit_idx   = idx_q;
    assign bus.in_gap    = gap_q;
    assign bus.inc_score = inc_q;
    assign bus.score     = score_q;
    assign bus.lives     = lives_q;
    assign bus.game_over = over;

endmodule

// File: tb/tb_elevator_collision_tracker.sv
// Bench: two trackers (8-bit and 2-bit score) on shared stimulus,
// checked each cycle against a frame-level game model.
module tb_elevator_collision_tracker;
    import elevator_pkg::*;

    localparam int HOLDOFF = 30;
    localparam int LIVES   = 3;

    typedef struct {
        bit       over;
        int       lives;
        int       score;
        bit [2:0] arm;
        bit       holding;
        int       hit_frame;
        int       frame;
        bit       hit;
        int       hit_idx;
        bit       in_gap;
        bit       inc;
    } mdl_t;

    logic clk;
    logic rst_n;
    int   n_cmp = 0;
    int   n_bad = 0;

    int et[3], eb[3], el[3], er[3];
    int pt, pb, pl, pr;
    bit tk, rs;
    mdl_t ma, mb;

    elevator_collision_tracker_if #(.NUM_ELEV(3), .COORD_W(10), .SCORE_W(8)) ifa ();
    elevator_collision_tracker_if #(.NUM_ELEV(3), .COORD_W(10), .SCORE_W(2)) ifb ();

    elevator_collision_tracker #(
        .NUM_ELEV(3), .COORD_W(10), .SCORE_W(8), .LIVES(LIVES), .HOLDOFF(HOLDOFF)
    ) dut_a (
        .clk(clk), .rst_n(rst_n), .bus(ifa)
    );

    elevator_collision_tracker #(
        .NUM_ELEV(3), .COORD_W(10), .SCORE_W(2), .LIVES(LIVES), .HOLDOFF(HOLDOFF)
    ) dut_b (
        .clk(clk), .rst_n(rst_n), .bus(ifb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string n, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d (t=%0t)", n, act, exp, $time);
        end
    endtask

    function automatic mdl_t mreset();
        mdl_t m;
        m.over = 0; m.lives = LIVES; m.score = 0; m.arm = 3'b111;
        m.holding = 0; m.hit_frame = 0; m.frame = 0;
        m.hit = 0; m.hit_idx = 0; m.in_gap = 0; m.inc = 0;
        return m;
    endfunction

    // One clock of the game rules, using the stimulus variables.
    function automatic mdl_t mstep(mdl_t m, int smax);
        int pc, low, ns;
        bit g, vov, al, gp;
        m.hit = 0;
        m.inc = 0;
        if (rs) begin
            m.over = 0; m.lives = LIVES; m.score = 0;
            m.arm = 3'b111; m.holding = 0;
            return m;
        end
        if (!tk || m.over) return m;
        m.frame++;
        pc = 0; low = -1; g = 0;
        for (int i = 0; i < 3; i++) begin
            vov = (pt >= eb[i]) && (pt < et[i]);
            al  = (pl >= el[i]) && (pr <= er[i]);
            gp  = al && (pt >= eb[i]) && (pb <= et[i]);
            if (gp) g = 1;
            if (vov && !gp && low < 0) low = i;
            if (m.arm[i] && pb >= et[i]) begin
                pc++;
                m.arm[i] = 0;
            end else if (pb < eb[i]) begin
                m.arm[i] = 1;
            end
        end
        ns = m.score + pc;
        if (ns > smax) ns = smax;
        m.inc = (ns != m.score);
        m.score = ns;
        m.in_gap = g;
        if (low >= 0 && !(m.holding && (m.frame - m.hit_frame) <= HOLDOFF)) begin
            m.lives--;
            m.hit = 1;
            m.hit_idx = low;
            m.holding = 1;
            m.hit_frame = m.frame;
            if (m.lives == 0) m.over = 1;
        end
        return m;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ma <= mreset();
            mb <= mreset();
        end else begin
            ma <= mstep(ma, 255);
            mb <= mstep(mb, 3);
        end
    end

    always @(negedge clk) begin
        check("A.hit", ifa.hit, ma.hit);
        check("A.hit_idx", ifa.hit_idx, ma.hit_idx);
        check("A.in_gap", ifa.in_gap, ma.in_gap);
        check("A.inc", ifa.inc_score, ma.inc);
        check("A.score", ifa.score, ma.score);
        check("A.lives", ifa.lives, ma.lives);
        check("A.over", ifa.game_over, ma.over);
        check("B.hit", ifb.hit, mb.hit);
        check("B.inc", ifb.inc_score, mb.inc);
        check("B.score", ifb.score, mb.score);
        check("B.lives", ifb.lives, mb.lives);
        check("B.over", ifb.game_over, mb.over);
    end

    task automatic drive();
        for (int i = 0; i < 3; i++) begin
            ifa.elev_top[i*10 +: 10] = 10'(et[i]);
            ifa.elev_bot[i*10 +: 10] = 10'(eb[i]);
            ifa.elev_l[i*10 +: 10]   = 10'(el[i]);
            ifa.elev_r[i*10 +: 10]   = 10'(er[i]);
            ifb.elev_top[i*10 +: 10] = 10'(et[i]);
            ifb.elev_bot[i*10 +: 10] = 10'(eb[i]);
            ifb.elev_l[i*10 +: 10]   = 10'(el[i]);
            ifb.elev_r[i*10 +: 10]   = 10'(er[i]);
        end
        ifa.pt = 10'(pt); ifa.pb = 10'(pb);
        ifa.pl = 10'(pl); ifa.pr = 10'(pr);
        ifb.pt = 10'(pt); ifb.pb = 10'(pb);
        ifb.pl = 10'(pl); ifb.pr = 10'(pr);
        ifa.frame_tick = tk; ifa.restart = rs;
        ifb.frame_tick = tk; ifb.restart = rs;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            drive();
            cyc();
        end
    endtask

    task automatic tick();
        tk = 1;
        drive();
        cyc();
        tk = 0;
        drive();
    endtask

    task automatic lane(input int i, input int b, input int t, input int l, input int r);
        eb[i] = b; et[i] = t; el[i] = l; er[i] = r;
    endtask

    initial begin
        rst_n = 1'b0;
        tk = 0; rs = 0;
        for (int i = 0; i < 3; i++) lane(i, 900, 950, 0, 0);
        pt = 0; pb = 10; pl = 0; pr = 0;
        ma = mreset();
        mb = mreset();
        idle(2);
        check("rst.lives", ifa.lives, 3);
        check("rst.score", ifa.score, 0);
        check("rst.hit", ifa.hit, 0);
        check("rst.over", ifa.game_over, 0);
        rst_n = 1'b1;
        idle(2);

        // in gap of lane 1: no hit
        lane(1, 100, 120, 40, 60);
        pl = 45; pr = 55; pt = 105; pb = 118;
        tick();
        check("gap.in_gap", ifa.in_gap, 1);
        check("gap.hit", ifa.hit, 0);
        check("gap.lives", ifa.lives, 3);

        // misaligned on lane 1: hit
        pl = 10; pr = 30; pt = 110; pb = 115;
        tick();
        check("hit1.hit", ifa.hit, 1);
        check("hit1.idx", ifa.hit_idx, 1);
        check("hit1.lives", ifa.lives, 2);
        check("hit1.in_gap", ifa.in_gap, 0);
        idle(1);
        check("hit1.pulse", ifa.hit, 0);

        // holdoff: 30 ignored ticks, then the 31st hits
        for (int k = 1; k <= HOLDOFF; k++) begin
            tick();
            check("hold.hit", ifa.hit, 0);
        end
        check("hold.lives", ifa.lives, 2);
        tick();
        check("hit2.hit", ifa.hit, 1);
        check("hit2.lives", ifa.lives, 1);

        // scoring on lanes 0 and 2
        lane(1, 900, 950, 0, 0);
        lane(0, 100, 120, 0, 1000);
        lane(2, 100, 120, 0, 1000);
        pt = 200; pb = 119;
        tick();
        check("sc0.score", ifa.score, 0);
        pb = 125;
        tick();
        check("sc1.score", ifa.score, 2);
        check("sc1.inc", ifa.inc_score, 1);
        check("sc1.B", ifb.score, 2);
        repeat (5) begin
            tick();
            check("sc.held", ifa.score, 2);
            check("sc.noinc", ifa.inc_score, 0);
        end
        pb = 90;
        tick();
        pb = 125;
        tick();
        check("sc2.score", ifa.score, 4);
        check("sc2.B", ifb.score, 3);
        check("sc2.Binc", ifb.inc_score, 1);
        pb = 90;
        tick();
        pb = 125;
        tick();
        check("sc3.score", ifa.score, 6);
        check("sat.B", ifb.score, 3);
        check("sat.Binc", ifb.inc_score, 0);

        // leave holdoff, then last life lost together with a pass
        pb = 90;
        repeat (25) tick();
        check("play.over", ifa.game_over, 0);
        lane(1, 100, 120, 40, 60);
        pt = 110; pb = 125;
        tick();
        check("end.hit", ifa.hit, 1);
        check("end.idx", ifa.hit_idx, 0);
        check("end.lives", ifa.lives, 0);
        check("end.score", ifa.score, 9);
        check("end.over", ifa.game_over, 1);
        pt = 200; pb = 90;
        repeat (3) begin
            tick();
            check("frz.score", ifa.score, 9);
            check("frz.over", ifa.game_over, 1);
        end

        // restart wins over a same-clock tick
        pt = 110; pb = 115;
        rs = 1; tk = 1;
        drive();
        cyc();
        rs = 0; tk = 0;
        drive();
        check("rs.lives", ifa.lives, 3);
        check("rs.score", ifa.score, 0);
        check("rs.over", ifa.game_over, 0);
        check("rs.hit", ifa.hit, 0);
        tick();
        check("rs.hit2", ifa.hit, 1);
        check("rs.idx", ifa.hit_idx, 1);
        check("rs.lives2", ifa.lives, 2);

        // build score 5 in HOLD, then async reset
        lane(1, 100, 120, 0, 1000);
        pt = 200; pb = 90;
        tick();
        pb = 125;
        tick();
        pb = 90;
        tick();
        lane(1, 900, 950, 0, 0);
        pb = 125;
        tick();
        check("pre.score", ifa.score, 5);
        check("pre.lives", ifa.lives, 2);
        #1;
        rst_n = 1'b0;
        #1;
        check("arst.score", ifa.score, 0);
        check("arst.lives", ifa.lives, 3);
        check("arst.hit", ifa.hit, 0);
        check("arst.over", ifa.game_over, 0);
        idle(2);
        rst_n = 1'b1;
        idle(2);
        tick();
        check("post.lives", ifa.lives, 3);
        idle(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
